// File: rtl/vanilla_scoreboard_latency_tracker.sv
// vanilla_scoreboard_latency_tracker
// Observational scoreboard monitor: tracks pending register writes per
// category, how long each has been outstanding, reports retirements with
// their set-to-clear latency, keeps the worst latency per category and
// flags sets that target an already-pending register.
module vanilla_scoreboard_latency_tracker #(
    parameter int els_p             = 32,
    parameter int reg_addr_width_lp = $clog2(els_p),
    parameter int num_cat_p         = 4,
    parameter int age_width_p       = 16,
    parameter int ignore_r0_p       = 1
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        set_v_i,
    input  logic [reg_addr_width_lp-1:0]                set_id_i,
    input  logic [num_cat_p-1:0]                        set_cat_i,
    input  logic                                        clear_v_i,
    input  logic [reg_addr_width_lp-1:0]                clear_id_i,
    output logic [els_p*num_cat_p-1:0]                  pending_o,
    output logic [els_p*age_width_p-1:0]                age_o,
    output logic [num_cat_p*(reg_addr_width_lp+1)-1:0]  outstanding_o,
    output logic                                        retire_v_o,
    output logic [reg_addr_width_lp-1:0]                retire_id_o,
    output logic [num_cat_p-1:0]                        retire_cat_o,
    output logic [age_width_p-1:0]                      retire_latency_o,
    output logic [num_cat_p*age_width_p-1:0]            max_latency_o,
    output logic                                        violation_o
);

    localparam int                     CNT_W   = reg_addr_width_lp + 1;
    localparam logic [age_width_p-1:0] AGE_MAX = {age_width_p{1'b1}};

    logic [num_cat_p-1:0]         r_pend [els_p];
    logic [age_width_p-1:0]       r_age  [els_p];
    logic [age_width_p-1:0]       r_max  [num_cat_p];
    logic                         r_retire_v;
    logic [reg_addr_width_lp-1:0] r_retire_id;
    logic [num_cat_p-1:0]         r_retire_cat;
    logic [age_width_p-1:0]       r_retire_lat;
    logic                         r_violation;

    logic                         w_set_ev;
    logic                         w_set_busy;
    logic                         w_clr_ev;
    logic [num_cat_p-1:0]         w_clr_pend;
    logic [age_width_p-1:0]       w_clr_age;
    logic [age_width_p-1:0]       w_lat;
    logic [CNT_W-1:0]             w_cnt [num_cat_p];

    // Qualify set/clear events and compute the saturating retire latency.
    always_comb begin
        w_set_ev   = set_v_i && (set_cat_i != {num_cat_p{1'b0}})
                     && !((ignore_r0_p != 0) && (set_id_i == {reg_addr_width_lp{1'b0}}));
        w_set_busy = |r_pend[set_id_i];
        w_clr_pend = r_pend[clear_id_i];
        w_clr_age  = r_age[clear_id_i];
        // A set to the same register in the same cycle wins over the clear.
        w_clr_ev   = clear_v_i && (|w_clr_pend) && !(w_set_ev && (set_id_i == clear_id_i));
        if (w_clr_age == AGE_MAX) begin
            w_lat = AGE_MAX;
        end else begin
            w_lat = w_clr_age + {{(age_width_p-1){1'b0}}, 1'b1};
        end
    end

    // Per-register pending bits and age counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                r_pend[i] <= {num_cat_p{1'b0}};
                r_age[i]  <= {age_width_p{1'b0}};
            end
        end else begin
            for (int i = 0; i < els_p; i++) begin
                if (w_set_ev && (set_id_i == reg_addr_width_lp'(i))) begin
                    r_pend[i] <= r_pend[i] | set_cat_i;
                    r_age[i]  <= {age_width_p{1'b0}};
                end else if (w_clr_ev && (clear_id_i == reg_addr_width_lp'(i))) begin
                    r_pend[i] <= {num_cat_p{1'b0}};
                    r_age[i]  <= {age_width_p{1'b0}};
                end else if (|r_pend[i]) begin
                    if (r_age[i] != AGE_MAX) begin
                        r_age[i] <= r_age[i] + {{(age_width_p-1){1'b0}}, 1'b1};
                    end else begin
                        r_age[i] <= r_age[i];
                    end
                end else begin
                    r_age[i] <= {age_width_p{1'b0}};
                end
            end
        end
    end

    // Registered retire report; data holds its last value between pulses.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_retire_v   <= 1'b0;
            r_retire_id  <= {reg_addr_width_lp{1'b0}};
            r_retire_cat <= {num_cat_p{1'b0}};
            r_retire_lat <= {age_width_p{1'b0}};
        end else begin
            r_retire_v <= w_clr_ev;
            if (w_clr_ev) begin
                r_retire_id  <= clear_id_i;
                r_retire_cat <= w_clr_pend;
                r_retire_lat <= w_lat;
            end else begin
                r_retire_id  <= r_retire_id;
                r_retire_cat <= r_retire_cat;
                r_retire_lat <= r_retire_lat;
            end
        end
    end

    // Worst-case retire latency per category.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int c = 0; c < num_cat_p; c++) begin
                r_max[c] <= {age_width_p{1'b0}};
            end
        end else begin
            for (int c = 0; c < num_cat_p; c++) begin
                if (w_clr_ev && w_clr_pend[c] && (w_lat > r_max[c])) begin
                    r_max[c] <= w_lat;
                end else begin
                    r_max[c] <= r_max[c];
                end
            end
        end
    end

    // Sticky flag for a set that targets an already-pending register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_violation <= 1'b0;
        end else if (w_set_ev && w_set_busy) begin
            r_violation <= 1'b1;
        end else begin
            r_violation <= r_violation;
        end
    end

    // Per-category popcount of pending registers.
    always_comb begin
        for (int c = 0; c < num_cat_p; c++) begin
            w_cnt[c] = {CNT_W{1'b0}};
            for (int i = 0; i < els_p; i++) begin
                w_cnt[c] = w_cnt[c] + CNT_W'(r_pend[i][c]);
            end
        end
    end

    for (genvar gi = 0; gi < els_p; gi++) begin : g_reg_out
        assign pending_o[gi*num_cat_p +: num_cat_p]  = r_pend[gi];
        assign age_o[gi*age_width_p +: age_width_p]  = r_age[gi];
    end

    for (genvar gc = 0; gc < num_cat_p; gc++) begin : g_cat_out
        assign outstanding_o[gc*CNT_W +: CNT_W]           = w_cnt[gc];
        assign max_latency_o[gc*age_width_p +: age_width_p] = r_max[gc];
    end

    assign retire_v_o       = r_retire_v;
    assign retire_id_o      = r_retire_id;
    assign retire_cat_o     = r_retire_cat;
    assign retire_latency_o = r_retire_lat;
    assign violation_o      = r_violation;

endmodule

// File: tb/tb_vanilla_scoreboard_latency_tracker.sv
// Self-checking bench for vanilla_scoreboard_latency_tracker: directed
// scenarios followed by random traffic, compared against a model that
// remembers the edge at which each register was set and derives ages and
// latencies from edge-count differences.
module tb_vanilla_scoreboard_latency_tracker;

    localparam int ELS = 32;
    localparam int AW  = 5;
    localparam int NC  = 4;
    localparam int AGW = 4;
    localparam int CW  = AW + 1;
    localparam int SAT = (1 << AGW) - 1;

    logic               clk_i = 1'b0;
    logic               reset_i;
    logic               set_v_i;
    logic [AW-1:0]      set_id_i;
    logic [NC-1:0]      set_cat_i;
    logic               clear_v_i;
    logic [AW-1:0]      clear_id_i;
    logic [ELS*NC-1:0]  pending_o;
    logic [ELS*AGW-1:0] age_o;
    logic [NC*CW-1:0]   outstanding_o;
    logic               retire_v_o;
    logic [AW-1:0]      retire_id_o;
    logic [NC-1:0]      retire_cat_o;
    logic [AGW-1:0]     retire_latency_o;
    logic [NC*AGW-1:0]  max_latency_o;
    logic               violation_o;

    vanilla_scoreboard_latency_tracker #(
        .els_p(ELS), .num_cat_p(NC), .age_width_p(AGW), .ignore_r0_p(1)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .set_v_i(set_v_i), .set_id_i(set_id_i), .set_cat_i(set_cat_i),
        .clear_v_i(clear_v_i), .clear_id_i(clear_id_i),
        .pending_o(pending_o), .age_o(age_o), .outstanding_o(outstanding_o),
        .retire_v_o(retire_v_o), .retire_id_o(retire_id_o),
        .retire_cat_o(retire_cat_o), .retire_latency_o(retire_latency_o),
        .max_latency_o(max_latency_o), .violation_o(violation_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    // Reference model state
    logic [NC-1:0] m_pend [ELS];
    int            m_set_edge [ELS];
    int            m_max [NC];
    logic          m_viol;
    logic          m_ret_v;
    int            m_ret_id;
    logic [NC-1:0] m_ret_cat;
    int            m_ret_lat;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [127:0] e_pend, e_age;
        logic [NC*CW-1:0]  e_out;
        logic [NC*AGW-1:0] e_max;
        int d, cnt;
        e_pend = '0; e_age = '0; e_out = '0; e_max = '0;
        for (int i = 0; i < ELS; i++) begin
            e_pend[i*NC +: NC] = m_pend[i];
            if (m_pend[i] != 4'd0) begin
                d = edge_n - m_set_edge[i];
                if (d > SAT) d = SAT;
                e_age[i*AGW +: AGW] = AGW'(d);
            end
        end
        for (int c = 0; c < NC; c++) begin
            cnt = 0;
            for (int i = 0; i < ELS; i++) cnt += int'(m_pend[i][c]);
            e_out[c*CW +: CW] = CW'(cnt);
            e_max[c*AGW +: AGW] = AGW'(m_max[c]);
        end
        chk("pending", 128'(pending_o), e_pend);
        chk("age", 128'(age_o), e_age);
        chk("outstanding", 128'(outstanding_o), 128'(e_out));
        chk("max_latency", 128'(max_latency_o), 128'(e_max));
        chk("violation", 128'(violation_o), 128'(m_viol));
        chk("retire_v", 128'(retire_v_o), 128'(m_ret_v));
        if (m_ret_v) begin
            chk("retire_id", 128'(retire_id_o), 128'(m_ret_id));
            chk("retire_cat", 128'(retire_cat_o), 128'(m_ret_cat));
            chk("retire_lat", 128'(retire_latency_o), 128'(m_ret_lat));
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then check.
    task automatic step(input logic sv, input int sid, input logic [NC-1:0] sc,
                        input logic cv, input int cid, input logic rst);
        logic set_ev, clr_ev;
        int lat;
        reset_i = rst; set_v_i = sv; set_id_i = AW'(sid); set_cat_i = sc;
        clear_v_i = cv; clear_id_i = AW'(cid);
        @(posedge clk_i);
        edge_n++;
        if (rst) begin
            for (int i = 0; i < ELS; i++) begin m_pend[i] = '0; m_set_edge[i] = 0; end
            for (int c = 0; c < NC; c++) m_max[c] = 0;
            m_viol = 1'b0; m_ret_v = 1'b0; m_ret_id = 0; m_ret_cat = '0; m_ret_lat = 0;
        end else begin
            set_ev = sv && (sc != 4'd0) && (sid != 0);
            clr_ev = cv && (m_pend[cid] != 4'd0) && !(set_ev && sid == cid);
            m_ret_v = clr_ev;
            if (clr_ev) begin
                lat = edge_n - m_set_edge[cid];
                if (lat > SAT) lat = SAT;
                m_ret_id = cid; m_ret_cat = m_pend[cid]; m_ret_lat = lat;
                for (int c = 0; c < NC; c++)
                    if (m_pend[cid][c] && lat > m_max[c]) m_max[c] = lat;
                m_pend[cid] = '0;
            end
            if (set_ev) begin
                if (m_pend[sid] != 4'd0) m_viol = 1'b1;
                m_pend[sid] = m_pend[sid] | sc;
                m_set_edge[sid] = edge_n;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 4'd0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        logic [127:0] snap;
        // Reset state
        step(1'b1, 7, 4'hF, 1'b1, 7, 1'b1);
        step(1'b0, 0, 4'd0, 1'b0, 0, 1'b1);
        chk("rst_pending", 128'(pending_o), 128'd0);
        chk("rst_retire", 128'(retire_v_o), 128'd0);

        // Reg 5, cat 0100, cleared 7 edges later
        step(1'b1, 5, 4'b0100, 1'b0, 0, 1'b0);
        chk("t1_out_up", 128'(outstanding_o[2*CW +: CW]), 128'd1);
        idle(6);
        step(1'b0, 0, 4'd0, 1'b1, 5, 1'b0);
        chk("t1_rv", 128'(retire_v_o), 128'd1);
        chk("t1_lat", 128'(retire_latency_o), 128'd7);
        chk("t1_max2", 128'(max_latency_o[2*AGW +: AGW]), 128'd7);
        chk("t1_out_dn", 128'(outstanding_o[2*CW +: CW]), 128'd0);
        idle(1);
        chk("t1_pulse_end", 128'(retire_v_o), 128'd0);

        // Regs 3 and 4 back to back
        step(1'b1, 3, 4'b0001, 1'b0, 0, 1'b0);
        chk("t2_out1", 128'(outstanding_o[0 +: CW]), 128'd1);
        step(1'b1, 4, 4'b0001, 1'b0, 0, 1'b0);
        chk("t2_out2", 128'(outstanding_o[0 +: CW]), 128'd2);
        idle(3);
        step(1'b0, 0, 4'd0, 1'b1, 3, 1'b0);
        chk("t2_out3", 128'(outstanding_o[0 +: CW]), 128'd1);
        step(1'b0, 0, 4'd0, 1'b1, 4, 1'b0);
        chk("t2_out4", 128'(outstanding_o[0 +: CW]), 128'd0);
        chk("t2_rid", 128'(retire_id_o), 128'd4);
        chk("t2_max0", 128'(max_latency_o[0 +: AGW]), 128'd5);

        // Reg 0 ignored; clear of idle reg 12
        snap = 128'(pending_o);
        step(1'b1, 0, 4'b1111, 1'b0, 0, 1'b0);
        chk("t4_r0", 128'(pending_o), snap);
        step(1'b0, 0, 4'd0, 1'b1, 12, 1'b0);
        chk("t4_idle_clr", 128'(retire_v_o), 128'd0);

        // Age saturation
        step(1'b1, 2, 4'b1000, 1'b0, 0, 1'b0);
        idle(40);
        chk("t5_age_sat", 128'(age_o[2*AGW +: AGW]), 128'd15);
        step(1'b0, 0, 4'd0, 1'b1, 2, 1'b0);
        chk("t5_lat_sat", 128'(retire_latency_o), 128'd15);
        chk("t5_viol0", 128'(violation_o), 128'd0);

        // Same-cycle set and clear on busy reg 9
        step(1'b1, 9, 4'b0001, 1'b0, 0, 1'b0);
        idle(2);
        step(1'b1, 9, 4'b0010, 1'b1, 9, 1'b0);
        chk("t3_pend", 128'(pending_o[9*NC +: NC]), 128'd3);
        chk("t3_age", 128'(age_o[9*AGW +: AGW]), 128'd0);
        chk("t3_norv", 128'(retire_v_o), 128'd0);
        chk("t3_viol", 128'(violation_o), 128'd1);
        idle(2);
        chk("t3_viol_sticky", 128'(violation_o), 128'd1);

        // Reset with regs 1 and 2 pending
        step(1'b1, 1, 4'b0001, 1'b0, 0, 1'b0);
        step(1'b1, 2, 4'b0010, 1'b0, 0, 1'b0);
        step(1'b0, 0, 4'd0, 1'b1, 1, 1'b1);
        chk("t6_pend0", 128'(pending_o), 128'd0);
        chk("t6_max0", 128'(max_latency_o), 128'd0);
        chk("t6_norv", 128'(retire_v_o), 128'd0);
        step(1'b1, 6, 4'b0100, 1'b0, 0, 1'b0);
        idle(2);
        step(1'b0, 0, 4'd0, 1'b1, 6, 1'b0);
        chk("t6_lat", 128'(retire_latency_o), 128'd3);

        // Random traffic on a narrow register window to force collisions
        for (int n = 0; n < 2000; n++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 4'($urandom),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vanilla_scoreboard_latency_tracker.md
# vanilla_scoreboard_latency_tracker

Testbench-side scoreboard monitor for the vanilla core. It generalises the fixed four-category integer/float scoreboard tracking to a parametrised register count and category count. For every pending register write it also records how long it has been outstanding, when it retires, and the worst-case latency per category. It also flags scoreboard protocol violations. It sits beside the core in the testbench, fed from ID-stage issue events and writeback clear events, and is purely observational.

## Interface

Parameters:
- `els_p`, 32: number of tracked architectural registers.
- `reg_addr_width_lp`, `$clog2(els_p)`: register index width.
- `num_cat_p`, 4: number of pending categories, e.g. idiv/fdiv, dram, global, group.
- `age_width_p`, 16: width of the age and latency counters.
- `ignore_r0_p`, 1: when 1, set events to register 0 are dropped.

Ports (`clk_i` and `reset_i` first):
- `clk_i`, in, 1: the only clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `set_v_i`, in, 1: an instruction leaves ID (caller already qualified it with no stall and no flush).
- `set_id_i`, in, `reg_addr_width_lp`: destination register of the set.
- `set_cat_i`, in, `num_cat_p`: category mask to mark pending. Zero means no-op.
- `clear_v_i`, in, 1: writeback clear event.
- `clear_id_i`, in, `reg_addr_width_lp`: register being cleared.
- `pending_o`, out, `els_p*num_cat_p`: pending bits, register-major.
- `age_o`, out, `els_p*age_width_p`: cycles outstanding per register.
- `outstanding_o`, out, `num_cat_p*(reg_addr_width_lp+1)`: per-category count of pending registers.
- `retire_v_o`, out, 1: one-cycle pulse reporting a retirement.
- `retire_id_o`, out, `reg_addr_width_lp`: register that retired.
- `retire_cat_o`, out, `num_cat_p`: categories that were pending at retirement.
- `retire_latency_o`, out, `age_width_p`: set-to-clear latency in cycles.
- `max_latency_o`, out, `num_cat_p*age_width_p`: worst retire latency seen per category.
- `violation_o`, out, 1: sticky; set by a set event that targets an already-pending register.

## Operation

Per-register state:
- `pend_r[i]`, `num_cat_p` bits.
- `age_r[i]`, `age_width_p` bits.

A register i is "busy" when `|pend_r[i]`.

Set event:
- Condition: `set_v_i & |set_cat_i`, and not (`ignore_r0_p` with `set_id_i==0`).
- `pend_r[set_id_i] <= pend_r | set_cat_i`.
- `age_r <= 0`.
- If the register was already busy, `violation_o <= 1`. The bits are still ORed in and the age is still restarted.

Clear event (`clear_v_i`) when register `clear_id_i` is busy and not being set this cycle:
- `pend_r <= 0`.
- Retire output is registered: `retire_v_o=1`, `retire_id_o=clear_id_i`, `retire_cat_o=old pend_r`, `retire_latency_o=age_r+1`, saturating at all-ones.
- For each category c in `retire_cat_o`: `max_latency_r[c] <= max(max_latency_r[c], latency)`, using the same latency value.

Other cases:
- Clear of a non-busy register: no state change, no retire pulse.
- Set and clear to the same register in the same cycle: the set wins. Pending bits become `old|set_cat_i`, age restarts at 0, no retire pulse. The violation rule applies using the old busy state.
- Set and clear to different registers in the same cycle: both take effect independently.
- Age: every cycle a register is busy and not being set, `age_r[i]` increments, saturating at `2^age_width_p-1`. Non-busy registers hold age 0.

Outputs:
- `outstanding_o[c]` is the combinational popcount over i of `pend_r[i][c]`.
- `pending_o` and `age_o` are direct register outputs.

## Timing

- Reset, one cycle of `reset_i` high: all pending bits, ages, `max_latency_o`, `violation_o` and `retire_v_o` go to 0, and retire data goes to 0. Events presented during reset are ignored. Reset in the middle of outstanding entries discards them without a retire pulse.
- Set sampled at edge t: `pending_o` reflects it after t and `age_o` reads 0. The register reads age k after k further edges.
- Clear sampled at edge t+k (k ≥ 1) after a set at edge t:
  - `retire_v_o` is high for exactly the cycle after edge t+k, with `retire_latency_o=k`.
  - The pending bits read 0 in that same cycle.
  - `max_latency_o` is updated in that same cycle.
- Back-to-back retires on consecutive cycles give consecutive single-cycle pulses. There is no throttling.
- No backpressure, no handshake: every event is consumed the cycle it is presented.

## Test plan

- Set reg 5 with cat mask 0b0100 at cycle 0, clear at cycle 7 → `retire_v_o` pulses in cycle 8 with id 5, cat 0b0100, latency 7; `max_latency[2]=7`; `outstanding[2]` goes 1 then 0.
- Set regs 3 (cat 0b0001) and 4 (cat 0b0001) in consecutive cycles, clear both in consecutive cycles → `outstanding[0]` goes 1, 2, 1, 0; two single-cycle retire pulses; `max_latency[0]` holds the larger of the two latencies.
- Set and clear reg 9 in the same cycle while it is busy → pending bits stay set, age reads 0, no retire pulse, `violation_o=1` and stays 1.
- With `ignore_r0_p=1`, set reg 0 → nothing goes pending; clear of idle reg 12 → no retire pulse and no state change.
- With `age_width_p=4`, hold reg 2 busy for 40 cycles, then clear → `age_o` saturates at 15 and `retire_latency_o=15`.
- Assert reset while regs 1 and 2 are pending → the next cycle all outputs are 0 and no retire pulse occurs; a new set/clear afterwards behaves normally.
